// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   - state_e    : controller state encoding
//   - REG_ZERO   : architectural zero register (never a real hazard source)
//   - lat_ctrl_t : per-latch stall/flush/select bundle driven to the datapath
//   - is_load_use: load-use hazard predicate for the D/E stage pair
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_m;
        logic flush_w;
        logic pc_src_m;
    } lat_ctrl_t;

    // A load in E whose destination feeds either D-stage source.
    function automatic logic is_load_use(input logic       mem_to_reg_e,
                                         input logic [4:0] write_reg_e,
                                         input logic [4:0] rs_d,
                                         input logic [4:0] rt_d);
        return mem_to_reg_e && (write_reg_e != REG_ZERO) &&
               ((write_reg_e == rs_d) || (write_reg_e == rt_d));
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Datapath <-> controller bundle.
//   master : datapath side (drives hazard/memory status, receives stall/flush)
//   slave  : controller side (pipe_ctrl)
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             MemtoRegE;
    logic [4:0]       WriteRegE;
    logic [4:0]       RsD;
    logic [4:0]       RtD;
    logic             MemtoRegM;
    logic             MemWriteM;
    logic             BranchM;
    logic             ZeroM;
    logic             dmem_ack;
    logic             dmem_req;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic             FlushW;
    logic             PCSrcM;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output MemtoRegE, WriteRegE, RsD, RtD, MemtoRegM, MemWriteM,
               BranchM, ZeroM, dmem_ack,
        input  dmem_req, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushM, FlushW, PCSrcM,
               mem_err, stall_cycles, flush_events
    );

    modport slave (
        input  MemtoRegE, WriteRegE, RsD, RtD, MemtoRegM, MemWriteM,
               BranchM, ZeroM, dmem_ack,
        output dmem_req, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushM, FlushW, PCSrcM,
               mem_err, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter used for the performance counters.
//   clk, rst : clock, synchronous active-high reset (clears to 0)
//   inc      : count enable; ignored once the counter reaches all-ones
//   q        : current count
module sat_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;
endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pipe_ctrl_if.slave - hazard inputs, memory handshake,
//              latch stall/flush/select outputs, error flag, perf counters
// Stage controls are combinational from state and inputs; state, timeout
// counter, error flag and counters are registered.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic     clk,
    input  logic     rst,
    pipe_ctrl_if.slave bus
);
    localparam int unsigned TCNT_W = $clog2(MEM_TIMEOUT + 1);

    state_e            r_state;
    state_e            w_next_state;
    logic [TCNT_W-1:0] r_tcnt;
    logic [TCNT_W-1:0] w_next_tcnt;
    logic              r_mem_err;
    logic              w_next_mem_err;
    lat_ctrl_t         w_ctrl;
    logic              w_flush_inc;
    logic              w_stall_inc;
    logic              w_mem_op;
    logic              w_taken;
    logic              w_load_use;

    assign w_mem_op   = bus.MemtoRegM | bus.MemWriteM;
    assign w_taken    = bus.BranchM & bus.ZeroM & ~w_mem_op;
    assign w_load_use = is_load_use(bus.MemtoRegE, bus.WriteRegE, bus.RsD, bus.RtD);

    // State, timeout counter and sticky error register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_tcnt    <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_tcnt    <= w_next_tcnt;
            r_mem_err <= w_next_mem_err;
        end
    end

    // Next state and latch controls; priority rst > mem stall > branch > load-use
    always_comb begin
        w_ctrl         = '0;
        w_next_state   = r_state;
        w_next_tcnt    = r_tcnt;
        w_next_mem_err = r_mem_err;
        w_flush_inc    = 1'b0;

        if (rst) begin
            w_ctrl.flush_d = 1'b1;
            w_ctrl.flush_e = 1'b1;
            w_ctrl.flush_m = 1'b1;
            w_ctrl.flush_w = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_op && !bus.dmem_ack) begin
                        w_ctrl.stall_f = 1'b1;
                        w_ctrl.stall_d = 1'b1;
                        w_ctrl.stall_e = 1'b1;
                        w_ctrl.stall_m = 1'b1;
                        w_ctrl.flush_w = 1'b1;
                        w_next_state   = ST_MEM_WAIT;
                        w_next_tcnt    = TCNT_W'(1);
                    end else if (w_taken) begin
                        w_ctrl.pc_src_m = 1'b1;
                        w_ctrl.flush_d  = 1'b1;
                        w_ctrl.flush_e  = 1'b1;
                        w_ctrl.flush_m  = 1'b1;
                        w_flush_inc     = 1'b1;
                    end else if (w_load_use) begin
                        w_ctrl.stall_f = 1'b1;
                        w_ctrl.stall_d = 1'b1;
                        w_ctrl.flush_e = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    // An ack in the timeout cycle still completes the access.
                    if (bus.dmem_ack) begin
                        w_next_state = ST_RUN;
                        w_next_tcnt  = '0;
                    end else begin
                        w_ctrl.stall_f = 1'b1;
                        w_ctrl.stall_d = 1'b1;
                        w_ctrl.stall_e = 1'b1;
                        w_ctrl.stall_m = 1'b1;
                        w_ctrl.flush_w = 1'b1;
                        if (r_tcnt == TCNT_W'(MEM_TIMEOUT)) begin
                            w_next_mem_err = 1'b1;
                            w_next_state   = ST_HALT;
                            w_next_tcnt    = '0;
                        end else begin
                            w_next_tcnt = r_tcnt + TCNT_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    w_ctrl.stall_f = 1'b1;
                    w_ctrl.stall_d = 1'b1;
                    w_ctrl.stall_e = 1'b1;
                    w_ctrl.stall_m = 1'b1;
                    w_ctrl.flush_w = 1'b1;
                end
                default: begin
                    w_next_state = ST_RUN;
                    w_next_tcnt  = '0;
                end
            endcase
        end
    end

    assign w_stall_inc = ~rst & w_ctrl.stall_f;

    assign bus.dmem_req = w_mem_op & (r_state != ST_HALT) & ~rst;
    assign bus.StallF   = w_ctrl.stall_f;
    assign bus.StallD   = w_ctrl.stall_d;
    assign bus.StallE   = w_ctrl.stall_e;
    assign bus.StallM   = w_ctrl.stall_m;
    assign bus.FlushD   = w_ctrl.flush_d;
    assign bus.FlushE   = w_ctrl.flush_e;
    assign bus.FlushM   = w_ctrl.flush_m;
    assign bus.FlushW   = w_ctrl.flush_w;
    assign bus.PCSrcM   = w_ctrl.pc_src_m;
    assign bus.mem_err  = r_mem_err;

    sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_stall_inc),
        .q   (bus.stall_cycles)
    );

    sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_flush_inc),
        .q   (bus.flush_events)
    );
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: MEM_TIMEOUT=4, 4-bit counters so that
// saturation is reachable in a few cycles.
module tb_pipe_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    pipe_ctrl_if #(.CNT_W(4)) bus ();

    pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.MemtoRegE = 1'b0;
        bus.WriteRegE = 5'd0;
        bus.RsD       = 5'd0;
        bus.RtD       = 5'd0;
        bus.MemtoRegM = 1'b0;
        bus.MemWriteM = 1'b0;
        bus.BranchM   = 1'b0;
        bus.ZeroM     = 1'b0;
        bus.dmem_ack  = 1'b0;
    endtask

    function automatic logic [3:0] stalls();
        return {bus.StallF, bus.StallD, bus.StallE, bus.StallM};
    endfunction

    function automatic logic [3:0] flushes();
        return {bus.FlushD, bus.FlushE, bus.FlushM, bus.FlushW};
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();

        // Reset: all flushes, no stalls, request blocked even with a store in M
        bus.MemWriteM = 1'b1;
        settle();
        chk("rst_stall", 32'(stalls()), 32'h0);
        chk("rst_flush", 32'(flushes()), 32'hF);
        chk("rst_pcsrc", 32'(bus.PCSrcM), 32'h0);
        chk("rst_req", 32'(bus.dmem_req), 32'h0);
        tick();
        tick();
        chk("rst_err", 32'(bus.mem_err), 32'h0);
        chk("rst_scnt", 32'(bus.stall_cycles), 32'h0);
        chk("rst_fcnt", 32'(bus.flush_events), 32'h0);
        rst = 1'b0;
        idle();
        settle();

        // 1. Load-use on rs: one bubble
        bus.MemtoRegE = 1'b1;
        bus.WriteRegE = 5'd8;
        bus.RsD       = 5'd8;
        settle();
        chk("lu_stall", 32'(stalls()), 32'hC);
        chk("lu_flush", 32'(flushes()), 32'h4);
        chk("lu_req", 32'(bus.dmem_req), 32'h0);
        tick();
        bus.MemtoRegE = 1'b0;
        settle();
        chk("lu_after_stall", 32'(stalls()), 32'h0);
        chk("lu_scnt", 32'(bus.stall_cycles), 32'h1);
        // Destination r0 is never a hazard
        bus.MemtoRegE = 1'b1;
        bus.WriteRegE = 5'd0;
        bus.RsD       = 5'd0;
        settle();
        chk("lu_r0_stall", 32'(stalls()), 32'h0);
        tick();
        chk("lu_r0_scnt", 32'(bus.stall_cycles), 32'h1);
        // Hazard through rt
        bus.WriteRegE = 5'd9;
        bus.RsD       = 5'd3;
        bus.RtD       = 5'd9;
        settle();
        chk("lu_rt_stall", 32'(stalls()), 32'hC);
        tick();
        idle();
        settle();
        chk("lu_rt_scnt", 32'(bus.stall_cycles), 32'h2);

        // 2. Store with 3 wait cycles then ack
        bus.MemWriteM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("st_wait_stall", 32'(stalls()), 32'hF);
            chk("st_wait_flush", 32'(flushes()), 32'h1);
            chk("st_wait_req", 32'(bus.dmem_req), 32'h1);
            tick();
        end
        bus.dmem_ack = 1'b1;
        settle();
        chk("st_ack_stall", 32'(stalls()), 32'h0);
        chk("st_ack_req", 32'(bus.dmem_req), 32'h1);
        tick();
        idle();
        settle();
        chk("st_run_stall", 32'(stalls()), 32'h0);
        chk("st_scnt", 32'(bus.stall_cycles), 32'h5);

        // 3. Taken branch with a concurrent load-use: branch wins
        bus.BranchM   = 1'b1;
        bus.ZeroM     = 1'b1;
        bus.MemtoRegE = 1'b1;
        bus.WriteRegE = 5'd8;
        bus.RsD       = 5'd8;
        settle();
        chk("br_pcsrc", 32'(bus.PCSrcM), 32'h1);
        chk("br_flush", 32'(flushes()), 32'hE);
        chk("br_stall", 32'(stalls()), 32'h0);
        tick();
        chk("br_fcnt", 32'(bus.flush_events), 32'h1);
        chk("br_scnt", 32'(bus.stall_cycles), 32'h5);
        idle();
        bus.BranchM = 1'b1;
        settle();
        chk("br_nt_pcsrc", 32'(bus.PCSrcM), 32'h0);
        chk("br_nt_flush", 32'(flushes()), 32'h0);
        tick();
        chk("br_nt_fcnt", 32'(bus.flush_events), 32'h1);
        // Branch coinciding with a completing memory op is not taken
        bus.ZeroM     = 1'b1;
        bus.MemtoRegM = 1'b1;
        bus.dmem_ack  = 1'b1;
        settle();
        chk("br_memop_pcsrc", 32'(bus.PCSrcM), 32'h0);
        chk("br_memop_stall", 32'(stalls()), 32'h0);
        tick();
        idle();
        settle();

        // 5. Ack in the same cycle tcnt reaches MEM_TIMEOUT
        bus.MemtoRegM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("to_ack_wait", 32'(stalls()), 32'hF);
            tick();
        end
        bus.dmem_ack = 1'b1;
        settle();
        chk("to_ack_stall", 32'(stalls()), 32'h0);
        tick();
        idle();
        settle();
        chk("to_ack_err", 32'(bus.mem_err), 32'h0);
        chk("to_ack_run", 32'(stalls()), 32'h0);
        chk("to_ack_scnt", 32'(bus.stall_cycles), 32'h9);

        // 4. Load never acked: HALT after 4 wait cycles
        bus.MemtoRegM = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("to_err_pre", 32'(bus.mem_err), 32'h0);
            tick();
        end
        bus.BranchM = 1'b1;
        bus.ZeroM   = 1'b1;
        settle();
        chk("halt_err", 32'(bus.mem_err), 32'h1);
        chk("halt_stall", 32'(stalls()), 32'hF);
        chk("halt_flush", 32'(flushes()), 32'h1);
        chk("halt_req", 32'(bus.dmem_req), 32'h0);
        chk("halt_pcsrc", 32'(bus.PCSrcM), 32'h0);
        chk("halt_scnt", 32'(bus.stall_cycles), 32'hE);
        tick();
        chk("sat_scnt_1", 32'(bus.stall_cycles), 32'hF);
        tick();
        chk("sat_scnt_2", 32'(bus.stall_cycles), 32'hF);
        chk("halt_hold", 32'(stalls()), 32'hF);
        rst = 1'b1;
        settle();
        chk("halt_rst_stall", 32'(stalls()), 32'h0);
        chk("halt_rst_flush", 32'(flushes()), 32'hF);
        chk("halt_rst_req", 32'(bus.dmem_req), 32'h0);
        tick();
        rst = 1'b0;
        idle();
        settle();
        chk("halt_rst_err", 32'(bus.mem_err), 32'h0);
        chk("halt_rst_scnt", 32'(bus.stall_cycles), 32'h0);
        chk("halt_rst_fcnt", 32'(bus.flush_events), 32'h0);
        chk("halt_rst_run", 32'(stalls()), 32'h0);

        // 6. Reset in the middle of MEM_WAIT aborts the access
        bus.MemWriteM = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        settle();
        chk("mw_rst_flush", 32'(flushes()), 32'hF);
        chk("mw_rst_stall", 32'(stalls()), 32'h0);
        chk("mw_rst_req", 32'(bus.dmem_req), 32'h0);
        tick();
        rst = 1'b0;
        idle();
        settle();
        chk("mw_rst_run", 32'(stalls()), 32'h0);
        chk("mw_rst_req_idle", 32'(bus.dmem_req), 32'h0);

        // flush_events saturation via back-to-back taken branches
        bus.BranchM = 1'b1;
        bus.ZeroM   = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_fcnt_14", 32'(bus.flush_events), 32'hE);
        tick();
        chk("sat_fcnt_15", 32'(bus.flush_events), 32'hF);
        tick();
        chk("sat_fcnt_hold", 32'(bus.flush_events), 32'hF);
        chk("sat_fcnt_scnt", 32'(bus.stall_cycles), 32'h0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
